// File: rtl/stream_rr_arb.sv
// Round-robin merge of NI valid-ready streams into one registered output stream; 1 cycle latency.
// Backpressure: accepts a new beat only when the output is empty or draining. Build with STREAM_ARB_LAST_EN for packet lock.
module stream_rr_arb #(
    parameter int W  = 32,
    parameter int NI = 4,
    localparam int SW = (NI > 1) ? $clog2(NI) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clk_en,
    input  logic [NI-1:0]          i_v,
    output logic [NI-1:0]          i_rdy,
    input  logic [NI-1:0][W-1:0]   i,
`ifdef STREAM_ARB_LAST_EN
    input  logic [NI-1:0]          i_last,
    output logic                   o_last,
`endif
    output logic                   o_v,
    input  logic                   o_rdy,
    output logic [W-1:0]           o,
    output logic [SW-1:0]          o_src
);

    generate
        if (W <= 0) begin : g_chk_w
            $fatal(1, "stream_rr_arb: W must be > 0");
        end
        if (NI < 2) begin : g_chk_ni
            $fatal(1, "stream_rr_arb: NI must be >= 2");
        end
    endgenerate

    logic           r_o_v;
    logic [W-1:0]   r_o;
    logic [SW-1:0]  r_o_src;
    logic [SW-1:0]  r_ptr;
`ifdef STREAM_ARB_LAST_EN
    logic           r_o_last;
    logic           r_lock;
    logic [SW-1:0]  r_lock_src;
`endif

    logic           w_can_load;
    logic           w_any;
    logic           w_load;
    logic           w_hi_hit;
    logic           w_lo_hit;
    logic [SW-1:0]  w_hi_g;
    logic [SW-1:0]  w_lo_g;
    logic [SW-1:0]  w_g;
    logic [SW-1:0]  w_ptr_nxt;
    logic [NI-1:0]  w_onehot;

    assign w_can_load = !r_o_v || o_rdy;

    // Descending scan: the last hit is the lowest index at/above ptr (hi) or overall (lo, the wrap case).
    always_comb begin
        w_hi_hit = 1'b0;
        w_hi_g   = '0;
        w_lo_hit = 1'b0;
        w_lo_g   = '0;
        for (int k = NI - 1; k >= 0; k--) begin
            if (i_v[k]) begin
                w_lo_hit = 1'b1;
                w_lo_g   = SW'(k);
                if (SW'(k) >= r_ptr) begin
                    w_hi_hit = 1'b1;
                    w_hi_g   = SW'(k);
                end
            end
        end
        w_g   = w_hi_hit ? w_hi_g : w_lo_g;
        w_any = w_lo_hit;
`ifdef STREAM_ARB_LAST_EN
        if (r_lock) begin
            w_g   = r_lock_src;
            w_any = i_v[r_lock_src];
        end
`endif
    end

    always_comb begin
        w_onehot = '0;
        for (int k = 0; k < NI; k++) begin
            w_onehot[k] = (SW'(k) == w_g);
        end
    end

    assign w_load    = clk_en && w_can_load && w_any;
    assign i_rdy     = w_load ? w_onehot : '0;
    assign w_ptr_nxt = (w_g == SW'(NI - 1)) ? '0 : w_g + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_o_v      <= 1'b0;
            r_o        <= '0;
            r_o_src    <= '0;
            r_ptr      <= '0;
`ifdef STREAM_ARB_LAST_EN
            r_o_last   <= 1'b0;
            r_lock     <= 1'b0;
            r_lock_src <= '0;
`endif
        end else if (clk_en) begin
            if (w_can_load && w_any) begin
                r_o_v   <= 1'b1;
                r_o     <= i[w_g];
                r_o_src <= w_g;
`ifdef STREAM_ARB_LAST_EN
                r_o_last <= i_last[w_g];
                // ptr only moves at packet end so the next packet starts after the winner.
                if (i_last[w_g]) begin
                    r_lock <= 1'b0;
                    r_ptr  <= w_ptr_nxt;
                end else begin
                    r_lock     <= 1'b1;
                    r_lock_src <= w_g;
                end
`else
                r_ptr <= w_ptr_nxt;
`endif
            end else if (r_o_v && o_rdy) begin
                r_o_v <= 1'b0;
            end
        end
    end

    assign o_v   = r_o_v;
    assign o     = r_o;
    assign o_src = r_o_src;
`ifdef STREAM_ARB_LAST_EN
    assign o_last = r_o_last;
`endif

endmodule

// File: tb/tb_stream_rr_arb.sv
// Directed bench for stream_rr_arb: NI=4 instance with a scoreboard on output beats, plus an NI=3 instance.
module tb_stream_rr_arb;

    logic              clk = 1'b0;
    logic              rst;
    logic              clk_en;

    logic [3:0]        i_v4;
    logic [3:0]        i_rdy4;
    logic [3:0][31:0]  i4;
    logic              o_v4;
    logic              o_rdy4;
    logic [31:0]       o4;
    logic [1:0]        o_src4;

    logic [2:0]        i_v3;
    logic [2:0]        i_rdy3;
    logic [2:0][7:0]   i3;
    logic              o_v3;
    logic              o_rdy3;
    logic [7:0]        o3;
    logic [1:0]        o_src3;

`ifdef STREAM_ARB_LAST_EN
    logic [3:0]        i_last4;
    logic              o_last4;
    logic [2:0]        i_last3;
    logic              o_last3;
`endif

    int                total = 0;
    int                bad   = 0;
    logic [33:0]       sb[$];

    always #5 clk = ~clk;

    stream_rr_arb #(.W(32), .NI(4)) u4 (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .i_v    (i_v4),
        .i_rdy  (i_rdy4),
        .i      (i4),
`ifdef STREAM_ARB_LAST_EN
        .i_last (i_last4),
        .o_last (o_last4),
`endif
        .o_v    (o_v4),
        .o_rdy  (o_rdy4),
        .o      (o4),
        .o_src  (o_src4)
    );

    stream_rr_arb #(.W(8), .NI(3)) u3 (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .i_v    (i_v3),
        .i_rdy  (i_rdy3),
        .i      (i3),
`ifdef STREAM_ARB_LAST_EN
        .i_last (i_last3),
        .o_last (o_last3),
`endif
        .o_v    (o_v3),
        .o_rdy  (o_rdy3),
        .o      (o3),
        .o_src  (o_src3)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] s, input logic [31:0] d);
        sb.push_back({s, d});
    endtask

    // Retire the beat the coming edge will drain, then advance one cycle.
    task automatic cyc();
        logic [33:0] e;
        if (clk_en && !rst && o_v4 && o_rdy4) begin
            if (sb.size() == 0) begin
                chk("sb_nonempty", 64'(sb.size()), 64'd1);
            end else begin
                e = sb.pop_front();
                chk("o", 64'(o4), 64'(e[31:0]));
                chk("o_src", 64'(o_src4), 64'(e[33:32]));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst    = 1'b1;
        clk_en = 1'b1;
        i_v4   = '0;
        o_rdy4 = 1'b1;
        i_v3   = '0;
        o_rdy3 = 1'b1;
        for (int k = 0; k < 4; k++) i4[k] = 32'h10 + 32'(k);
        for (int k = 0; k < 3; k++) i3[k] = 8'h0;
`ifdef STREAM_ARB_LAST_EN
        i_last4 = 4'b1111;
        i_last3 = 3'b111;
`endif
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Idle after reset
        for (int n = 0; n < 5; n++) begin
            chk("idle_o_v", 64'(o_v4), 64'd0);
            chk("idle_i_rdy", 64'(i_rdy4), 64'd0);
            chk("idle_o_src", 64'(o_src4), 64'd0);
            cyc();
        end

        // All inputs valid: strict rotation, one beat per cycle
        i_v4 = 4'b1111;
        for (int n = 0; n < 8; n++) begin
            #1;
            chk("rr_i_rdy", 64'(i_rdy4), 64'd1 << (n % 4));
            chk("rr_o_v", 64'(o_v4), 64'(n > 0));
            push(2'(n % 4), 32'h10 + 32'(n % 4));
            cyc();
        end
        i_v4 = '0;
        #1;
        cyc();
        chk("rr_drained_o_v", 64'(o_v4), 64'd0);
        chk("rr_sb_empty", 64'(sb.size()), 64'd0);

        // Backpressure: hold output, then reload in the draining cycle
        o_rdy4 = 1'b0;
        i_v4   = 4'b1111;
        #1;
        chk("bp_first_rdy", 64'(i_rdy4), 64'd1);
        push(2'd0, 32'h10);
        cyc();
        for (int n = 0; n < 4; n++) begin
            chk("bp_i_rdy", 64'(i_rdy4), 64'd0);
            chk("bp_o_v", 64'(o_v4), 64'd1);
            chk("bp_o", 64'(o4), 64'h10);
            chk("bp_o_src", 64'(o_src4), 64'd0);
            cyc();
        end
        o_rdy4 = 1'b1;
        #1;
        chk("bp_nobubble_rdy", 64'(i_rdy4), 64'd2);
        push(2'd1, 32'h11);
        cyc();
        i_v4 = '0;
        #1;
        cyc();

        // Clock enable low freezes everything
        i_v4 = 4'b1111;
        #1;
        chk("ce_pre_rdy", 64'(i_rdy4), 64'd4);
        push(2'd2, 32'h12);
        cyc();
        clk_en = 1'b0;
        #1;
        for (int n = 0; n < 3; n++) begin
            chk("ce_i_rdy", 64'(i_rdy4), 64'd0);
            chk("ce_o_v", 64'(o_v4), 64'd1);
            chk("ce_o", 64'(o4), 64'h12);
            chk("ce_o_src", 64'(o_src4), 64'd2);
            cyc();
        end

        // Reset with an item in flight (clk_en still low) drops it and clears ptr
        rst = 1'b1;
        @(posedge clk); #1;
        rst    = 1'b0;
        clk_en = 1'b1;
        sb.delete();
        i_v4 = '0;
        #1;
        chk("rst_o_v", 64'(o_v4), 64'd0);
        chk("rst_o", 64'(o4), 64'd0);
        chk("rst_o_src", 64'(o_src4), 64'd0);
        i_v4 = 4'b1111;
        #1;
        chk("rst_ptr0_rdy", 64'(i_rdy4), 64'd1);
        push(2'd0, 32'h10);
        cyc();

        // Sparse requests skip idle inputs and wrap
        i_v4 = 4'b1010;
        for (int n = 0; n < 3; n++) begin
            logic [1:0] s;
            s = (n == 1) ? 2'd3 : 2'd1;
            #1;
            chk("sparse_i_rdy", 64'(i_rdy4), 64'd1 << s);
            push(s, 32'h10 + 32'(s));
            cyc();
        end
        i_v4 = 4'b0001;
        #1;
        chk("wrap_i_rdy", 64'(i_rdy4), 64'd1);
        push(2'd0, 32'h10);
        cyc();
        i_v4 = '0;
        #1;
        cyc();
        chk("sparse_drained", 64'(o_v4), 64'd0);

`ifdef STREAM_ARB_LAST_EN
        // Packet lock: input 1 keeps the grant for 3 beats while input 0 waits
        i_last4 = 4'b0000;
        i_v4    = 4'b0011;
        #1;
        chk("lock_b1_rdy", 64'(i_rdy4), 64'd2);
        push(2'd1, 32'h11);
        cyc();
        chk("lock_b1_last", 64'(o_last4), 64'd0);
        i_v4 = 4'b0001;
        #1;
        chk("lock_idle_src_rdy", 64'(i_rdy4), 64'd0);
        cyc();
        i_v4  = 4'b0011;
        i4[1] = 32'h21;
        #1;
        chk("lock_b2_rdy", 64'(i_rdy4), 64'd2);
        push(2'd1, 32'h21);
        cyc();
        i4[1]   = 32'h31;
        i_last4 = 4'b0010;
        #1;
        chk("lock_b3_rdy", 64'(i_rdy4), 64'd2);
        push(2'd1, 32'h31);
        cyc();
        chk("lock_b3_last", 64'(o_last4), 64'd1);
        #1;
        chk("unlock_rdy", 64'(i_rdy4), 64'd1);
        push(2'd0, 32'h10);
        cyc();
        i_v4 = '0;
        #1;
        cyc();
        i_last4 = 4'b1111;
        i4[1]   = 32'h11;
`endif
        chk("final_sb_empty", 64'(sb.size()), 64'd0);

        // NI=3: a lone request on the top input, ptr wraps modulo 3
        i_v3 = 3'b100;
        for (int n = 0; n < 4; n++) begin
            i3[2] = 8'hA0 + 8'(n);
            #1;
            chk("ni3_i_rdy", 64'(i_rdy3), 64'd4);
            cyc();
            chk("ni3_o_v", 64'(o_v3), 64'd1);
            chk("ni3_o", 64'(o3), 64'hA0 + 64'(n));
            chk("ni3_o_src", 64'(o_src3), 64'd2);
        end
        i_v3 = 3'b111;
        #1;
        chk("ni3_ptr_wrap_rdy", 64'(i_rdy3), 64'd1);
        i_v3 = '0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
